// File: rtl/ssd_scan_ctl_n.sv
`default_nettype none
// ssd_scan_ctl_n: multiplexed seven-segment scan controller with frame-locked
// data snapshot, optional inter-digit guard cycles and leading-zero blanking.
module ssd_scan_ctl_n #(
   parameter int NUM_DIGITS   = 4,
   parameter int DATA_W       = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD_CYCLES = 0,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [NUM_DIGITS*DATA_W-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]        digit_en,
   input  logic                         lz_en,
   output logic [NUM_DIGITS-1:0]        ssd_ctl,
   output logic [DATA_W-1:0]            ssd_in,
   output logic [IDX_W-1:0]             digit_idx,
   output logic                         frame_tick
);

   localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      PH_GUARD = 1'b0,
      PH_DRIVE = 1'b1
   } phase_t;

   localparam phase_t PH_FIRST = (GUARD_CYCLES > 0) ? PH_GUARD : PH_DRIVE;

   phase_t                         phase, phase_nxt;
   logic [CNT_W-1:0]               cnt, cnt_nxt;
   logic [IDX_W-1:0]               idx, idx_nxt;
   logic                           wrap;
   logic [NUM_DIGITS*DATA_W-1:0]   sh_data;
   logic [NUM_DIGITS-1:0]          sh_mask;
   logic                           sh_lz;
   logic                           tick;
   logic                           en_q;
   logic [NUM_DIGITS-1:0]          visible;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase   <= PH_FIRST;
         cnt     <= '0;
         idx     <= '0;
         sh_data <= '0;
         sh_mask <= '0;
         sh_lz   <= 1'b0;
         tick    <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         tick  <= wrap;
         en_q  <= en;
         if (wrap) begin
            sh_data <= data_in;
            sh_mask <= digit_en;
            sh_lz   <= lz_en;
         end
      end
   end

   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      wrap      = 1'b0;
      if (en) begin
         if (phase == PH_GUARD) begin
            if (cnt == GUARD_LAST) begin
               phase_nxt = PH_DRIVE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end else if (cnt == DRIVE_LAST) begin
            phase_nxt = PH_FIRST;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
               idx_nxt = '0;
               wrap    = 1'b1;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
   end

   // A digit is lz-suppressed when it and everything above it is zero.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      visible  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero   = all_zero & (sh_data[i*DATA_W +: DATA_W] == '0);
         visible[i] = sh_mask[i] & ~(sh_lz & (i != 0) & all_zero);
      end
   end

   // en is registered so the blanking has no combinational input path.
   always_comb begin
      ssd_ctl = '1;
      ssd_in  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (en_q && (phase == PH_DRIVE) && (idx == IDX_W'(i)) && visible[i]) begin
            ssd_ctl[i] = 1'b0;
            ssd_in     = sh_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign digit_idx  = idx;
   assign frame_tick = tick;

endmodule
`default_nettype wire

// File: doc/ssd_scan_ctl_n.md
Name: ssd_scan_ctl_n

Overview:
Parametrised multiplexed seven-segment scan controller for NUM_DIGITS digits, with an internal refresh prescaler (no external divided clock).
- Snapshots all digit data once per frame, so a value never tears mid-frame.
- Inserts optional all-off guard cycles between digits to suppress ghosting.
- Supports per-digit blanking and leading-zero suppression.
- Sits between the counter/BCD logic and the BCD-to-segment decoder.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8).
DATA_W, 4, bits per digit value.
SCAN_DIV, 100000, clk cycles each digit is driven (>=1).
GUARD_CYCLES, 0, all-off clk cycles before each digit (0 = no guard phase).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable; 0 freezes counters and blanks the display
data_in  input  NUM_DIGITS*DATA_W  digit i value at bits [i*DATA_W +: DATA_W]; digit 0 = rightmost
digit_en  input  NUM_DIGITS  per-digit visible mask, 1 = shown
lz_en  input  1  leading-zero suppression enable
ssd_ctl  output  NUM_DIGITS  active-low digit select, at most one bit low
ssd_in  output  DATA_W  value of the selected digit, 0 when none selected
digit_idx  output  max(1,clog2(NUM_DIGITS))  index of the digit currently being scanned
frame_tick  output  1  one-cycle pulse marking the start of each frame

Behaviour:
- Reset (async, rst=1):
  - phase=GUARD if GUARD_CYCLES>0, else DRIVE; phase counter=0; idx=0.
  - Shadow data, shadow mask and shadow lz cleared to 0.
  - Outputs: ssd_ctl=all ones, ssd_in=0, digit_idx=0, frame_tick=0.
- All outputs are pure functions of registered state; there is no combinational path from inputs to outputs.
- Per-digit phases:
  - GUARD: lasts GUARD_CYCLES cycles; ssd_ctl all ones, ssd_in=0.
  - DRIVE: lasts SCAN_DIV cycles. If the digit is visible, ssd_ctl=~(1<<idx) and ssd_in=shadow[idx]. If not visible, it is driven as in GUARD.
- Transitions (only when en=1):
  - GUARD to DRIVE after GUARD_CYCLES cycles.
  - DRIVE to next digit after SCAN_DIV cycles. The next digit enters GUARD, or DRIVE if GUARD_CYCLES=0.
  - idx increments and wraps from NUM_DIGITS-1 to 0. Wrap is not power-of-2 based (e.g. NUM_DIGITS=6 gives 0..5).
- Frame period = NUM_DIGITS*(GUARD_CYCLES+SCAN_DIV) cycles.
- Snapshot:
  - On the clock edge where idx wraps to 0, data_in, digit_en and lz_en are captured into the shadow registers.
  - frame_tick is high for exactly the first cycle of the new frame.
  - The first frame after reset displays shadow=0. No frame_tick is issued before the first wrap.
  - Input changes within a frame have no effect until the next wrap.
- Visibility = shadow_mask[i] AND NOT suppressed[i].
  - With shadow lz=1, digit i (i>=1) is suppressed if shadow[i]==0 and every digit above i is 0 or suppressed.
  - Digit 0 is never suppressed by lz.
- en=0:
  - Phase counter, idx and shadow registers hold.
  - ssd_ctl forced to all ones, ssd_in=0, frame_tick=0.
  - On en returning to 1, scanning resumes from the held phase and count.
- Async reset mid-frame: outputs go to reset values immediately, without waiting for clk.
- SCAN_DIV=1 with GUARD_CYCLES=0: idx advances every cycle. NUM_DIGITS=1: idx stays 0, and frame_tick fires every period.
- Phase counter width is sized to max(SCAN_DIV, GUARD_CYCLES); no overflow is permitted.

Test Plan:
1. NUM_DIGITS=4, SCAN_DIV=3, GUARD_CYCLES=0, data_in=16'h4321, digit_en=4'hF, lz_en=0. After the first wrap, ssd_ctl cycles 1110,1101,1011,0111 with ssd_in 1,2,3,4, 3 cycles each. frame_tick is high once every 12 cycles.
2. Same setup with GUARD_CYCLES=1. Each digit is preceded by 1 cycle of ssd_ctl=1111, ssd_in=0. frame_tick period is 16 cycles.
3. data_in=16'h0070, lz_en=1, digit_en=4'hF. Digits 3 and 2 stay off (ssd_ctl bits high); digit 1 shows 7 and digit 0 shows 0. Then set data_in=16'h0000: only digit 0 lit, showing 0.
4. Change data_in from 16'h1111 to 16'h9999 mid-frame. The rest of the frame still shows 1; 9 appears starting with the cycle frame_tick=1.
5. Drop en for 5 cycles during digit 2 DRIVE. ssd_ctl=1111 and idx is held; after en=1, digit 2 completes its remaining cycles.
6. Assert rst asynchronously mid-DRIVE. ssd_ctl=1111, ssd_in=0 and digit_idx=0 before the next clk edge; the first post-reset frame displays zeros. Also run NUM_DIGITS=6: idx wraps 5 to 0.
